// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO, MTHI/MTLO writes and flush abort.
// Latency: WIDTH+1 edges from accept to hi/lo/done (1 edge for divide by zero; 2..WIDTH+1 for MUL with early-out).
// Backpressure: busy stalls the pipeline front; start while busy is ignored. Build option: MULDIV_EARLY_OUT_EN.
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    // MUL: running product. DIV: {remainder, dividend bits shifting into quotient}.
    logic [2*WIDTH-1:0] acc;
    // MUL: multiplicand shifted left each step. DIV: divisor in the low half.
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               neg_q;
    logic               neg_r;
    logic               is_div;
    logic               dz_pend;

    logic               accept;
    logic               op_div;
    logic               op_dz;
    logic               sa;
    logic               sb;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [2*WIDTH-1:0] mul_acc_nxt;
    logic [WIDTH-1:0]   mplier_nxt;
    logic               mul_last;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_sub;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_acc_nxt;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Operand decode: signed ops take magnitudes; |most-negative| fits as unsigned 2^(WIDTH-1).
    always_comb begin
        accept = (state == IDLE) && start && !flush;
        op_div = op[1];
        op_dz  = op[1] && (b == '0);
        sa     = !op[0] && a[WIDTH-1];
        sb     = !op[0] && b[WIDTH-1];
        abs_a  = sa ? (~a + 1'b1) : a;
        abs_b  = sb ? (~b + 1'b1) : b;
    end

    // One shift-add multiply step and one restoring-divide step.
    always_comb begin
        mul_acc_nxt = acc + (mplier[0] ? mcand : '0);
        mplier_nxt  = mplier >> 1;
        div_shift   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge      = (div_shift >= {1'b0, mcand[WIDTH-1:0]});
        div_sub     = div_ge ? (div_shift - {1'b0, mcand[WIDTH-1:0]}) : div_shift;
        div_acc_nxt = {div_sub[WIDTH-1:0], acc[WIDTH-2:0], div_ge};
    end

`ifdef MULDIV_EARLY_OUT_EN
    // Stop as soon as no set multiplier bits remain; the product is already final.
    assign mul_last = (cnt == CNT_W'(1)) || (mplier_nxt == '0);
`else
    assign mul_last = (cnt == CNT_W'(1));
`endif

    // Sign correction applied at the FIX edge.
    always_comb begin
        prod_fix = neg_q ? (~acc + 1'b1) : acc;
        quot_fix = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
        rem_fix  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    end

    // Next-state selection; flush from any busy state returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (op_dz)       state_nxt = FIX;
                    else if (op_div) state_nxt = DIV;
                    else             state_nxt = MUL;
                end
            end
            MUL: begin
                if (flush)         state_nxt = IDLE;
                else if (mul_last) state_nxt = FIX;
            end
            DIV: begin
                if (flush)                    state_nxt = IDLE;
                else if (cnt == CNT_W'(1))    state_nxt = FIX;
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, datapath registers, HI/LO and registered status outputs.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state       <= IDLE;
            cnt         <= '0;
            acc         <= '0;
            mcand       <= '0;
            mplier      <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            is_div      <= 1'b0;
            dz_pend     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    // MTHI/MTLO land first; an op accepted on the same edge overwrites later.
                    if (mthi_we) hi <= wdata;
                    if (mtlo_we) lo <= wdata;
                    if (accept) begin
                        cnt         <= CNT_W'(WIDTH);
                        // Divide by zero keeps raw a for HI and all ones for LO.
                        acc         <= op_dz  ? {a, {WIDTH{1'b1}}} :
                                       op_div ? {{WIDTH{1'b0}}, abs_a} : '0;
                        mcand       <= {{WIDTH{1'b0}}, (op_div ? abs_b : abs_a)};
                        mplier      <= abs_b;
                        neg_q       <= sa ^ sb;
                        neg_r       <= sa;
                        is_div      <= op_div;
                        dz_pend     <= op_dz;
                        div_by_zero <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= mul_acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier_nxt;
                    cnt    <= cnt - 1'b1;
                end
                DIV: begin
                    acc <= div_acc_nxt;
                    cnt <= cnt - 1'b1;
                end
                FIX: begin
                    if (!flush) begin
                        done        <= 1'b1;
                        div_by_zero <= dz_pend;
                        if (dz_pend) begin
                            hi <= acc[2*WIDTH-1:WIDTH];
                            lo <= acc[WIDTH-1:0];
                        end else if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Directed-vector bench for mips_muldiv_unit at WIDTH=32 (default build).
// Checks results, latency, busy length, div-by-zero, overflow, flush, MTHI/MTLO and async reset.
// Inputs driven at negedge, outputs sampled 1 time unit after the rising edge.
module tb_mips_muldiv_unit;
    localparam int W = 32;

    logic         Clk = 1'b0;
    logic         Rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         flush = 1'b0;
    logic         mthi_we = 1'b0;
    logic         mtlo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int failures = 0;
    int lat;
    int bcnt;
    int done_seen;

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .Clk(Clk), .Rst(Rst), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op, wait (bounded) for done; lat counts edges after E0, bcnt counts busy samples from E0 on.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int l, output int bc);
        @(negedge Clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        l = 0;
        bc = busy ? 1 : 0;
        while (!done && l < 200) begin
            @(posedge Clk); #1;
            l++;
            if (busy) bc++;
        end
        check("op_done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic done_pulse_check(input string tag);
        @(posedge Clk); #1;
        check(tag, {63'd0, done}, 64'd0);
    endtask

    task automatic res(input string tag, input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        check({tag, "_hi"}, {32'd0, hi}, {32'd0, eh});
        check({tag, "_lo"}, {32'd0, lo}, {32'd0, el});
        check({tag, "_dz"}, {63'd0, div_by_zero}, {63'd0, edz});
    endtask

    initial begin
        // Reset state
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;

        // 1: MULTU max*max, latency and busy length
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bcnt);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy_cycles", 64'(bcnt), 64'd33);
        check("multu_busy_after", {63'd0, busy}, 64'd0);
        res("multu_max", 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        done_pulse_check("multu_done_one_cycle");

        // 2: signed multiply and divide
        do_op(2'b00, 32'hFFFF_FFFD, 32'd5, lat, bcnt);
        res("mult_neg3x5", 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000, lat, bcnt);
        res("mult_minxmin", 32'h4000_0000, 32'h0000_0000, 1'b0);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2, lat, bcnt);
        check("div_lat", 64'(lat), 64'd33);
        res("div_neg7by2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        do_op(2'b11, 32'hFFFF_FFFF, 32'h10, lat, bcnt);
        res("divu_max_by16", 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);

        // 3: divide by zero, flag hold, clear on next accept
        do_op(2'b11, 32'd100, 32'd0, lat, bcnt);
        check("dz_lat", 64'(lat), 64'd1);
        check("dz_busy_cycles", 64'(bcnt), 64'd1);
        res("divu_by0", 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
        repeat (3) @(posedge Clk);
        #1;
        check("dz_held", {63'd0, div_by_zero}, 64'd1);
        @(negedge Clk);
        op = 2'b11; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        check("dz_clear_on_accept", {63'd0, div_by_zero}, 64'd0);
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge Clk); #1;
            lat++;
        end
        res("divu_100by7", 32'd2, 32'd14, 1'b0);

        // 4: overflow case
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, lat, bcnt);
        res("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

        // 5: MTHI/MTLO preload, flush at E10, ignored start/MTHI while busy
        @(negedge Clk); mthi_we = 1'b1; wdata = 32'h1234;
        @(negedge Clk); mthi_we = 1'b0; mtlo_we = 1'b1; wdata = 32'h5678;
        @(negedge Clk); mtlo_we = 1'b0;
        #1;
        check("mthi_mtlo", {hi, lo}, {32'h1234, 32'h5678});
        op = 2'b01; a = 32'd7; b = 32'd9; start = 1'b1;
        @(posedge Clk); #1;                      // E0
        start = 1'b0;
        repeat (2) @(posedge Clk);               // E1, E2
        @(negedge Clk);
        mthi_we = 1'b1; wdata = 32'hDEAD; start = 1'b1; op = 2'b00;
        @(posedge Clk); #1;                      // E3
        mthi_we = 1'b0; start = 1'b0;
        check("busy_midop", {63'd0, busy}, 64'd1);
        repeat (6) @(posedge Clk);               // E4..E9
        @(negedge Clk); flush = 1'b1;
        @(posedge Clk); #1;                      // E10
        flush = 1'b0;
        check("flush_busy", {63'd0, busy}, 64'd0);
        check("flush_done", {63'd0, done}, 64'd0);
        check("flush_hilo", {hi, lo}, {32'h1234, 32'h5678});
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clk); #1;
            if (done || busy) done_seen++;
        end
        check("flush_no_late_done", 64'(done_seen), 64'd0);
        do_op(2'b01, 32'd7, 32'd9, lat, bcnt);
        check("post_flush_lat", 64'(lat), 64'd33);
        res("post_flush_7x9", 32'd0, 32'd63, 1'b0);

        // 6: async reset mid-DIV
        @(negedge Clk);
        op = 2'b10; a = 32'd1000; b = 32'd3; start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        repeat (14) @(posedge Clk);
        @(negedge Clk); Rst = 1'b1;
        #1;
        check("arst_busy", {63'd0, busy}, 64'd0);
        check("arst_done", {63'd0, done}, 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        @(negedge Clk); Rst = 1'b0;
        do_op(2'b01, 32'd3, 32'd4, lat, bcnt);
        check("post_rst_lat", 64'(lat), 64'd33);
        res("post_rst_3x4", 32'd0, 32'd12, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
